// File: rtl/task4.sv
// ARC4 24-bit key cracker: walks keys upward from 0, decrypts the
// length-prefixed ciphertext in the ct ROM and stops on the first key
// whose plaintext is all printable ASCII. The winning key goes to the
// six seven-segment displays.

// 256x8 single-port memory with registered read data (1-cycle latency).
module task4_spram (
    input  logic       clk_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    output logic [7:0] rdata_o
);
    logic [7:0] mem [256];

    // Write-first is not needed: the cracker never reads an address in the cycle it writes it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end
endmodule

// Cracking core: INIT / KSA / PRGA per candidate key with inline printable check.
module task4_crack (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [23:0] key_o,
    output logic        key_valid_o,
    output logic        done_o
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_NEXTKEY,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ph_q, ph_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [1:0]  m_q, m_d;

    logic [7:0]  s_addr, s_wdata, s_rdata;
    logic        s_we;
    logic [7:0]  ct_addr, ct_rdata;
    logic [7:0]  pt_addr, pt_wdata, unused_pt_rdata;
    logic        pt_we;

    logic [7:0]  kbyte, i_inc, j_ksa, j_prga, pad_addr, p_byte;

    // Names the rest of the design (and anyone probing c) refers to.
    logic [23:0] key;
    logic        key_valid;
    assign key       = key_q;
    assign key_valid = key_valid_q;

    assign key_o       = key;
    assign key_valid_o = key_valid;
    assign done_o      = (state_q == ST_DONE);

    task4_spram ct (
        .clk_i  (clk_i),
        .addr_i (ct_addr),
        .wdata_i(8'h00),
        .we_i   (1'b0),
        .rdata_o(ct_rdata)
    );

    task4_spram s (
        .clk_i  (clk_i),
        .addr_i (s_addr),
        .wdata_i(s_wdata),
        .we_i   (s_we),
        .rdata_o(s_rdata)
    );

    task4_spram pt (
        .clk_i  (clk_i),
        .addr_i (pt_addr),
        .wdata_i(pt_wdata),
        .we_i   (pt_we),
        .rdata_o(unused_pt_rdata)
    );

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Key byte for i mod 3, tracked by m_q so no divider is needed.
    always_comb begin
        kbyte = key_q[7:0];
        case (m_q)
            2'd0:    kbyte = key_q[23:16];
            2'd1:    kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase
    end

    assign i_inc    = i_q + 8'd1;
    assign j_ksa    = j_q + s_rdata + kbyte;
    assign j_prga   = j_q + s_rdata;
    assign pad_addr = si_q + sj_q;
    assign p_byte   = ct_rdata ^ s_rdata;

    // Control registers take the reset; datapath registers are always overwritten before use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ph_q        <= 3'd0;
            key_q       <= 24'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        i_q   <= i_d;
        j_q   <= j_d;
        k_q   <= k_d;
        len_q <= len_d;
        si_q  <= si_d;
        sj_q  <= sj_d;
        m_q   <= m_d;
    end

    // Next-state and memory port control. Each KSA step takes 4 cycles, each PRGA byte 6.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        m_d         = m_q;
        s_addr      = i_q;
        s_wdata     = 8'h00;
        s_we        = 1'b0;
        ct_addr     = 8'h00;
        pt_addr     = k_q;
        pt_wdata    = 8'h00;
        pt_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_INIT;
                i_d     = 8'd0;
            end

            ST_INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_we    = 1'b1;
                i_d     = i_inc;
                // ct address sits at 0 for the whole fill, so the length is ready at the end.
                if (i_q == 8'hFF) begin
                    state_d = ST_KSA;
                    ph_d    = 3'd0;
                    j_d     = 8'd0;
                    m_d     = 2'd0;
                    len_d   = ct_rdata;
                end
            end

            ST_KSA: begin
                case (ph_q)
                    3'd0: begin
                        s_addr = i_q;
                        ph_d   = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rdata;
                        j_d    = j_ksa;
                        s_addr = j_ksa;
                        ph_d   = 3'd2;
                    end
                    3'd2: begin
                        sj_d    = s_rdata;
                        s_addr  = i_q;
                        s_wdata = s_rdata;
                        s_we    = 1'b1;
                        ph_d    = 3'd3;
                    end
                    default: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_we    = 1'b1;
                        i_d     = i_inc;
                        m_d     = (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
                        ph_d    = 3'd0;
                        if (i_q == 8'hFF) begin
                            j_d = 8'd0;
                            k_d = 8'd1;
                            if (len_q == 8'd0) begin
                                state_d     = ST_DONE;
                                key_valid_d = 1'b1;
                            end else begin
                                state_d = ST_PRGA;
                            end
                        end
                    end
                endcase
            end

            ST_PRGA: begin
                ct_addr = k_q;
                case (ph_q)
                    3'd0: begin
                        i_d      = i_inc;
                        s_addr   = i_inc;
                        pt_addr  = 8'd0;
                        pt_wdata = len_q;
                        pt_we    = 1'b1;
                        ph_d     = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rdata;
                        j_d    = j_prga;
                        s_addr = j_prga;
                        ph_d   = 3'd2;
                    end
                    3'd2: begin
                        sj_d    = s_rdata;
                        s_addr  = i_q;
                        s_wdata = s_rdata;
                        s_we    = 1'b1;
                        ph_d    = 3'd3;
                    end
                    3'd3: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_we    = 1'b1;
                        ph_d    = 3'd4;
                    end
                    3'd4: begin
                        s_addr = pad_addr;
                        ph_d   = 3'd5;
                    end
                    default: begin
                        pt_addr  = k_q;
                        pt_wdata = p_byte;
                        pt_we    = 1'b1;
                        ph_d     = 3'd0;
                        if (!is_printable(p_byte)) begin
                            state_d = ST_NEXTKEY;
                        end else if (k_q == len_q) begin
                            state_d     = ST_DONE;
                            key_valid_d = 1'b1;
                        end else begin
                            k_d = k_q + 8'd1;
                        end
                    end
                endcase
            end

            ST_NEXTKEY: begin
                ph_d = 3'd0;
                if (key_q == 24'hFF_FFFF) begin
                    state_d = ST_DONE;
                end else begin
                    key_d   = key_q + 24'd1;
                    state_d = ST_INIT;
                    i_d     = 8'd0;
                end
            end

            default: begin
                state_d = ST_DONE;
            end
        endcase
    end
endmodule

// Board top: key cracker plus seven-segment and LED presentation.
module task4 (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    logic [23:0] key;
    logic        key_valid;
    logic        done;
    logic        unused_inputs;

    assign unused_inputs = ^{SW, KEY[2:0]};

    task4_crack c (
        .clk_i      (CLOCK_50),
        .rst_ni     (KEY[3]),
        .key_o      (key),
        .key_valid_o(key_valid),
        .done_o     (done)
    );

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Blank while searching, key when found, dashes when the key space ran out.
    always_comb begin
        HEX0 = 7'h7F;
        HEX1 = 7'h7F;
        HEX2 = 7'h7F;
        HEX3 = 7'h7F;
        HEX4 = 7'h7F;
        HEX5 = 7'h7F;
        if (done && key_valid) begin
            HEX0 = seg7(key[3:0]);
            HEX1 = seg7(key[7:4]);
            HEX2 = seg7(key[11:8]);
            HEX3 = seg7(key[15:12]);
            HEX4 = seg7(key[19:16]);
            HEX5 = seg7(key[23:20]);
        end else if (done) begin
            HEX0 = 7'b0111111;
            HEX1 = 7'b0111111;
            HEX2 = 7'b0111111;
            HEX3 = 7'b0111111;
            HEX4 = 7'b0111111;
            HEX5 = 7'b0111111;
        end
    end

    assign LEDR = {8'b0, key_valid, done};
endmodule

// File: tb/tb_task4.sv
// Directed bench for the ARC4 key cracker top.
module tb_task4;
    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int checks = 0;
    int errors = 0;
    int blank_bad;
    int cyc;

    logic [7:0]  msg [256];
    logic [7:0]  ctb [256];
    logic [7:0]  ks  [256];
    logic [23:0] exp_key;
    int          len;

    task4 dut (
        .CLOCK_50(clk),
        .KEY     (KEY),
        .SW      (SW),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5),
        .LEDR    (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_msg(input string str);
        len = str.len();
        for (int n = 0; n < len; n++) msg[n+1] = str[n];
    endtask

    // Reference ARC4 keystream for bytes 1..n.
    task automatic gen_ks(input logic [23:0] k, input int n);
        logic [7:0] sa [256];
        logic [7:0] kb [3];
        logic [7:0] j, t, ii;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int x = 0; x < 256; x++) sa[x] = x[7:0];
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + sa[x] + kb[x % 3];
            t = sa[x];
            sa[x] = sa[j];
            sa[j] = t;
        end
        ii = 8'd0;
        j = 8'd0;
        for (int x = 1; x <= n; x++) begin
            ii = ii + 8'd1;
            j = j + sa[ii];
            t = sa[ii];
            sa[ii] = sa[j];
            sa[j] = t;
            t = sa[ii] + sa[j];
            ks[x] = sa[t];
        end
    endtask

    task automatic encrypt_and_load(input logic [23:0] k);
        gen_ks(k, len);
        dut.c.ct.mem[0] = len[7:0];
        for (int n = 1; n <= len; n++) begin
            ctb[n] = msg[n] ^ ks[n];
            dut.c.ct.mem[n] = ctb[n];
        end
    endtask

    // First key, counting up from 0, whose decryption is all printable.
    task automatic model_search(output logic [23:0] found);
        logic ok;
        logic hit;
        logic [7:0] b;
        hit = 1'b0;
        found = 24'h0;
        for (int kk = 0; kk < 4096 && !hit; kk++) begin
            gen_ks(kk[23:0], len);
            ok = 1'b1;
            for (int n = 1; n <= len; n++) begin
                b = ctb[n] ^ ks[n];
                if (b < 8'h20 || b > 8'h7E) ok = 1'b0;
            end
            if (ok) begin
                found = kk[23:0];
                hit = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        cyc = 0;
        blank_bad = 0;
        while (!LEDR[0] && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!LEDR[0] && ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}} || LEDR !== 10'h0))
                blank_bad++;
        end
        check("done_within_budget", {31'b0, LEDR[0]}, 32'd1);
        check("blank_during_search", blank_bad, 32'd0);
    endtask

    task automatic check_hex_all(input string tag, input logic [6:0] g);
        check({tag, "_hex1"}, {25'b0, HEX1}, {25'b0, g});
        check({tag, "_hex2"}, {25'b0, HEX2}, {25'b0, g});
        check({tag, "_hex3"}, {25'b0, HEX3}, {25'b0, g});
        check({tag, "_hex4"}, {25'b0, HEX4}, {25'b0, g});
        check({tag, "_hex5"}, {25'b0, HEX5}, {25'b0, g});
    endtask

    initial begin
        KEY = 4'b0111;
        SW  = 10'h0;

        // Scenario 1: 45-byte message under key 000001.
        set_msg("The quick brown fox jumps over the lazy dog!!");
        encrypt_and_load(24'h000001);
        repeat (3) @(negedge clk);
        check("reset_key", dut.c.key, 32'h0);
        check("reset_key_valid", {31'b0, dut.c.key_valid}, 32'h0);
        check("reset_hex0", {25'b0, HEX0}, 32'h7F);
        check_hex_all("reset", 7'h7F);
        check("reset_ledr", {22'b0, LEDR}, 32'h0);
        KEY[3] = 1'b1;
        wait_done(9000);
        check("s1_key", dut.c.key, 32'h1);
        check("s1_key_valid", {31'b0, dut.c.key_valid}, 32'h1);
        check("s1_hex0", {25'b0, HEX0}, 32'b1111001);
        check_hex_all("s1", 7'b1000000);
        check("s1_ledr", {22'b0, LEDR}, 32'h3);
        check("s1_pt0", {24'b0, dut.c.pt.mem[0]}, 32'h2D);
        for (int n = 1; n <= 45; n++)
            check($sformatf("s1_pt%0d", n), {24'b0, dut.c.pt.mem[n]}, {24'b0, msg[n]});

        // Reset after DONE, then again part-way through KSA.
        @(negedge clk);
        KEY[3] = 1'b0;
        @(negedge clk);
        check("rst_done_key", dut.c.key, 32'h0);
        check("rst_done_ledr", {22'b0, LEDR}, 32'h0);
        check("rst_done_hex0", {25'b0, HEX0}, 32'h7F);
        KEY[3] = 1'b1;
        repeat (600) @(negedge clk);
        KEY[3] = 1'b0;
        @(negedge clk);
        check("rst_ksa_key", dut.c.key, 32'h0);
        check("rst_ksa_ledr", {22'b0, LEDR}, 32'h0);
        KEY[3] = 1'b1;
        wait_done(9000);
        check("s2_key", dut.c.key, 32'h1);
        check("s2_hex0", {25'b0, HEX0}, 32'b1111001);
        check("s2_ledr", {22'b0, LEDR}, 32'h3);

        // Scenario 3: key 000000.
        @(negedge clk);
        KEY[3] = 1'b0;
        set_msg("Zero key test: all six displays read 0 0 0 0!");
        encrypt_and_load(24'h000000);
        @(negedge clk);
        KEY[3] = 1'b1;
        wait_done(9000);
        check("s3_key", dut.c.key, 32'h0);
        check("s3_key_valid", {31'b0, dut.c.key_valid}, 32'h1);
        check("s3_hex0", {25'b0, HEX0}, 32'b1000000);
        check_hex_all("s3", 7'b1000000);

        // Scenario 4: key 00001A.
        @(negedge clk);
        KEY[3] = 1'b0;
        set_msg("Key 1A should show up as A on HEX0, 1 on HEX1");
        encrypt_and_load(24'h00001A);
        model_search(exp_key);
        @(negedge clk);
        KEY[3] = 1'b1;
        wait_done(45000);
        check("s4_key", dut.c.key, {8'b0, exp_key});
        check("s4_hex0", {25'b0, HEX0}, 32'b0001000);
        check("s4_hex1", {25'b0, HEX1}, 32'b1111001);
        check("s4_hex5", {25'b0, HEX5}, 32'b1000000);

        // Scenario 5: single-byte message; bytes past pt[1] untouched.
        @(negedge clk);
        KEY[3] = 1'b0;
        set_msg("Z");
        encrypt_and_load(24'h000003);
        model_search(exp_key);
        gen_ks(exp_key, 1);
        dut.c.pt.mem[2] = 8'hEE;
        @(negedge clk);
        KEY[3] = 1'b1;
        wait_done(9000);
        check("s5_key", dut.c.key, {8'b0, exp_key});
        check("s5_key_valid", {31'b0, dut.c.key_valid}, 32'h1);
        check("s5_pt0", {24'b0, dut.c.pt.mem[0]}, 32'h1);
        check("s5_pt1", {24'b0, dut.c.pt.mem[1]}, {24'b0, ctb[1] ^ ks[1]});
        check("s5_pt2_untouched", {24'b0, dut.c.pt.mem[2]}, 32'hEE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
